// File: rtl/text_pkg.sv
// Shared constants and types for the text-mode character buffer write path.
package text_pkg;

    localparam int COLS       = 80;
    localparam int ROWS       = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int COL_W      = 7;
    localparam int CHAR_W     = 6;
    localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CHAR_W-1:0] CLEAR_CHAR = 6'h3F;

    typedef enum logic {
        IDLE,
        CLEAR
    } sched_state_t;

    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [CHAR_W-1:0] chr;
    } char_req_t;

endpackage

// File: rtl/char_write_sched_if.sv
// Host request handshake, blanking input and row-buffer write bus of the scheduler.
interface char_write_sched_if #(
    parameter int ROWS = 4
) ();

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic             req_valid;
    logic             req_ready;
    logic [5:0]       req_char;
    logic [6:0]       req_col;
    logic [ROW_W-1:0] req_row;
    logic             clear_req;
    logic             video_active;
    logic [ROWS-1:0]  wr_en;
    logic [6:0]       wr_col;
    logic [5:0]       wr_char;
    logic             busy;
    logic             oob;

    modport master (
        output req_valid, req_char, req_col, req_row, clear_req, video_active,
        input  req_ready, wr_en, wr_col, wr_char, busy, oob
    );

    modport slave (
        input  req_valid, req_char, req_col, req_row, clear_req, video_active,
        output req_ready, wr_en, wr_col, wr_char, busy, oob
    );

endinterface

// File: rtl/char_req_fifo.sv
// Generic synchronous FIFO with first-word fall-through read data.
module char_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop_data = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/char_write_sched.sv
// Queues host character writes and issues them, or a full-screen clear, only during blanking.
module char_write_sched #(
    parameter int         COLS       = text_pkg::COLS,
    parameter int         ROWS       = text_pkg::ROWS,
    parameter int         FIFO_DEPTH = text_pkg::FIFO_DEPTH,
    parameter logic [5:0] CLEAR_CHAR = text_pkg::CLEAR_CHAR
) (
    input logic              clk,
    input logic              rst_n,
    char_write_sched_if.slave bus
);

    import text_pkg::*;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    sched_state_t     state;
    logic             clear_pend;
    logic [ROW_W-1:0] cell_row;
    logic [COL_W-1:0] cell_col;
    logic [ROWS-1:0]  wr_en;
    logic [COL_W-1:0] wr_col;
    logic [5:0]       wr_char;
    logic             oob;

    char_req_t push_req;
    char_req_t head_req;
    logic [$bits(char_req_t)-1:0] head_vec;
    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic head_oob;

    assign push_req = '{row: bus.req_row, col: bus.req_col, chr: bus.req_char};
    assign head_req = char_req_t'(head_vec);

    assign bus.req_ready = !fifo_full && !clear_pend && (state != CLEAR);
    assign push          = bus.req_valid && bus.req_ready;
    // Queued requests drain even while a clear is pending, preserving program order.
    assign pop           = (state == IDLE) && !fifo_empty && !bus.video_active;
    assign head_oob      = (int'(head_req.col) >= COLS) || (int'(head_req.row) >= ROWS);

    char_req_fifo #(
        .WIDTH ($bits(char_req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_req),
        .pop       (pop),
        .pop_data  (head_vec),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            clear_pend <= 1'b0;
            cell_row   <= '0;
            cell_col   <= '0;
            wr_en      <= '0;
            wr_col     <= '0;
            wr_char    <= '0;
            oob        <= 1'b0;
        end else begin
            wr_en <= '0;
            oob   <= 1'b0;
            if (bus.clear_req && !clear_pend && (state != CLEAR))
                clear_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (clear_pend && fifo_empty) begin
                        state    <= CLEAR;
                        cell_row <= '0;
                        cell_col <= '0;
                    end else if (pop) begin
                        if (head_oob) begin
                            oob <= 1'b1;
                        end else begin
                            wr_en[head_req.row] <= 1'b1;
                            wr_col              <= head_req.col;
                            wr_char             <= head_req.chr;
                        end
                    end
                end
                CLEAR: begin
                    // Counter holds while the display is reading the buffers.
                    if (!bus.video_active) begin
                        wr_en[cell_row] <= 1'b1;
                        wr_col          <= cell_col;
                        wr_char         <= CLEAR_CHAR;
                        if (cell_col == LAST_COL) begin
                            cell_col <= '0;
                            if (cell_row == LAST_ROW) begin
                                cell_row   <= '0;
                                clear_pend <= 1'b0;
                                state      <= IDLE;
                            end else begin
                                cell_row <= cell_row + 1'b1;
                            end
                        end else begin
                            cell_col <= cell_col + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.wr_en   = wr_en;
    assign bus.wr_col  = wr_col;
    assign bus.wr_char = wr_char;
    assign bus.oob     = oob;
    assign bus.busy    = !fifo_empty || clear_pend || (state != IDLE);

endmodule

// File: tb/tb_char_write_sched.sv
// Scoreboarded bench for char_write_sched: table-driven writes plus clear and reset sequences.
module tb_char_write_sched;

    typedef struct {
        bit         oob;
        logic [3:0] wr_en;
        logic [6:0] col;
        logic [5:0] chr;
    } exp_t;

    typedef struct {
        logic [1:0] row;
        logic [6:0] col;
        logic [5:0] chr;
        bit         oob;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   write_cnt = 0;
    logic va_last = 1'b0;
    exp_t exp_q[$];
    vec_t vecs[8];

    char_write_sched_if #(.ROWS(4)) bus ();

    char_write_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    always @(posedge clk) va_last <= bus.video_active;

    // Output monitor: every write or oob pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (bus.wr_en != 4'b0 || bus.oob)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got wr_en=%b oob=%b col=%0d chr=%h, expected nothing",
                         bus.wr_en, bus.oob, bus.wr_col, bus.wr_char);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.wr_en !== e.wr_en || bus.oob !== e.oob ||
                    (!e.oob && (bus.wr_col !== e.col || bus.wr_char !== e.chr))) begin
                    errors++;
                    $display("FAIL out_seq: got wr_en=%b oob=%b col=%0d chr=%h, expected wr_en=%b oob=%b col=%0d chr=%h",
                             bus.wr_en, bus.oob, bus.wr_col, bus.wr_char, e.wr_en, e.oob, e.col, e.chr);
                end
            end
            if (bus.wr_en != 4'b0) begin
                write_cnt++;
                checks++;
                if (va_last) begin
                    errors++;
                    $display("FAIL write_in_active: got write col=%0d while video_active was 1, expected none",
                             bus.wr_col);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_write(input logic [1:0] r, input logic [6:0] c, input logic [5:0] ch);
        exp_t e;
        e.oob = 1'b0; e.wr_en = 4'b0001 << r; e.col = c; e.chr = ch;
        exp_q.push_back(e);
    endtask

    task automatic push_oob();
        exp_t e;
        e.oob = 1'b1; e.wr_en = 4'b0; e.col = '0; e.chr = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_clear();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 80; c++)
                push_write(2'(r), 7'(c), 6'h3F);
    endtask

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input logic [1:0] r, input logic [6:0] c, input logic [5:0] ch, input bit is_oob);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_row   = r;
        bus.req_col   = c;
        bus.req_char  = ch;
        while (!bus.req_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.req_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: got req_ready=0 for %0d cycles, expected 1", n);
        end else begin
            if (is_oob) push_oob();
            else        push_write(r, c, ch);
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear_req = 1'b1;
        @(posedge clk); #1;
        bus.clear_req = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        int ready_bad;
        int wc;
        int n;

        vecs[0] = '{row: 2'd0, col: 7'd0,   chr: 6'h01, oob: 1'b0};
        vecs[1] = '{row: 2'd3, col: 7'd79,  chr: 6'h3E, oob: 1'b0};
        vecs[2] = '{row: 2'd1, col: 7'd80,  chr: 6'h15, oob: 1'b1};
        vecs[3] = '{row: 2'd1, col: 7'd40,  chr: 6'h2A, oob: 1'b0};
        vecs[4] = '{row: 2'd2, col: 7'd127, chr: 6'h00, oob: 1'b1};
        vecs[5] = '{row: 2'd2, col: 7'd78,  chr: 6'h3F, oob: 1'b0};
        vecs[6] = '{row: 2'd0, col: 7'd79,  chr: 6'h00, oob: 1'b0};
        vecs[7] = '{row: 2'd3, col: 7'd1,   chr: 6'h12, oob: 1'b0};

        bus.req_valid    = 1'b0;
        bus.req_row      = '0;
        bus.req_col      = '0;
        bus.req_char     = '0;
        bus.clear_req    = 1'b0;
        bus.video_active = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_wr_col", 32'(bus.wr_col), 0);
        chk("rst_wr_char", 32'(bus.wr_char), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_oob", 32'(bus.oob), 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 32'(bus.req_ready), 1);
        @(posedge clk); #1;

        // Single write in blanking, with latency
        send(2'd2, 7'd5, 6'h0A, 1'b0);
        chk("single_no_early_wr", 32'(bus.wr_en), 0);
        chk("single_busy_queued", 32'(bus.busy), 1);
        @(posedge clk); #1;
        chk("single_wr_en", 32'(bus.wr_en), 32'h4);
        chk("single_wr_col", 32'(bus.wr_col), 5);
        chk("single_wr_char", 32'(bus.wr_char), 32'h0A);
        @(posedge clk); #1;
        chk("single_wr_en_off", 32'(bus.wr_en), 0);
        chk("single_busy_off", 32'(bus.busy), 0);
        chk("single_hold_col", 32'(bus.wr_col), 5);

        // Gated during active video
        bus.video_active = 1'b1;
        wc = write_cnt;
        for (int i = 0; i < 4; i++)
            send(2'(i), 7'(10 + i), 6'(32 + i), 1'b0);
        chk("gated_ready_full", 32'(bus.req_ready), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("gated_no_writes", 32'(write_cnt - wc), 0);
        chk("gated_busy", 32'(bus.busy), 1);
        bus.video_active = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("gated_consecutive", 32'(bus.wr_en != 4'b0), 1);
        end
        wait_drain("gated_drain", 20);

        // Table-driven writes including out-of-range columns
        for (int i = 0; i < 8; i++)
            send(vecs[i].row, vecs[i].col, vecs[i].chr, vecs[i].oob);
        wait_drain("table_drain", 50);
        @(posedge clk); #1;
        chk("table_busy_off", 32'(bus.busy), 0);

        // Clear after queued writes; repeated clear_req ignored
        bus.video_active = 1'b1;
        send(2'd1, 7'd10, 6'h11, 1'b0);
        send(2'd3, 7'd0, 6'h22, 1'b0);
        push_clear();
        pulse_clear();
        chk("clear_ready_low", 32'(bus.req_ready), 0);
        chk("clear_busy", 32'(bus.busy), 1);
        pulse_clear();
        bus.video_active = 1'b0;
        ready_bad = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            if (n == 50) bus.clear_req = 1'b1;
            @(posedge clk); #1;
            bus.clear_req = 1'b0;
            if (exp_q.size() > 1 && bus.req_ready) ready_bad++;
            n++;
        end
        chk("clear_drain", exp_q.size(), 0);
        chk("clear_ready_during", ready_bad, 0);
        chk("clear_ready_after", 32'(bus.req_ready), 1);
        chk("clear_busy_after", 32'(bus.busy), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("clear_no_repeat", exp_q.size(), 0);

        // Clear paused by toggling video_active
        push_clear();
        pulse_clear();
        n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            bus.video_active = ($urandom_range(0, 2) == 0);
            @(posedge clk); #1;
            n++;
        end
        bus.video_active = 1'b0;
        chk("paused_drain", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("paused_busy_after", 32'(bus.busy), 0);

        // Reset in the middle of a clear
        push_clear();
        pulse_clear();
        n = 0;
        while (exp_q.size() > 220 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("midclear_reached", exp_q.size(), 220);
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", 32'(bus.wr_en), 0);
        chk("midrst_wr_col", 32'(bus.wr_col), 0);
        chk("midrst_wr_char", 32'(bus.wr_char), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_oob", 32'(bus.oob), 0);
        exp_q.delete();
        wc = write_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("postrst_busy", 32'(bus.busy), 0);
        chk("postrst_ready", 32'(bus.req_ready), 1);
        repeat (20) @(posedge clk);
        #1;
        chk("postrst_no_writes", 32'(write_cnt - wc), 0);

        // Normal operation resumes after reset
        send(2'd1, 7'd3, 6'h07, 1'b0);
        wait_drain("postrst_write", 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
